bus_transfer_arbiter: RTL and testbench
=======================================

Name: bus_transfer_arbiter

Overview:
- Shares the single internal bus among NUM_REQ requesters, each asking for one register-to-register move (src -> dst).
- Drives the bus-mux select, the source output-enable and a one-hot destination register enable.
- The destination register's enable input is driven by rin, so the move completes on one clock edge.
- Arbitration is round-robin; each granted transfer runs a fixed IDLE -> XFER -> ACK sequence.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- REG_SEL_W, 4, register index width; register file size is 2**REG_SEL_W.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-high reset.
- req  in  NUM_REQ  per-requester transfer request; must be held high until that requester's done pulse.
- src_sel  in  NUM_REQ*REG_SEL_W  flattened source index; requester i uses bits [i*REG_SEL_W +: REG_SEL_W].
- dst_sel  in  NUM_REQ*REG_SEL_W  flattened destination index, same packing as src_sel.
- grant  out  NUM_REQ  one-hot, high for the winning requester during XFER and ACK.
- bus_sel  out  REG_SEL_W  bus-mux select (source register index).
- bus_oe  out  1  source drive enable.
- rin  out  2**REG_SEL_W  one-hot destination register enable.
- done  out  NUM_REQ  one-cycle completion pulse to the winner.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - state = IDLE.
  - Round-robin pointer = 0.
  - Latched src/dst/winner = 0.
  - clear acts immediately (asynchronously), including mid-transfer: rin and bus_oe drop at once, no done is issued, and the aborted requester must re-request.
- IDLE:
  - If any req bit is high at the rising edge, latch the winner index and its src_sel/dst_sel slices, then go to XFER.
  - Otherwise stay in IDLE.
- XFER, exactly one cycle:
  - grant[winner]=1, bus_sel=latched src, bus_oe=1, rin[latched dst]=1.
  - All other rin bits are 0.
  - The destination register captures the bus at the edge ending XFER.
  - Next state: ACK.
- ACK, exactly one cycle:
  - done[winner]=1, grant held, bus_oe=0, rin=0.
  - Pointer becomes (winner+1) mod NUM_REQ.
  - Next state: IDLE.
- Latency and throughput:
  - req sampled at edge E; XFER is the cycle after E; done is the second cycle after E.
  - One transfer per 3 cycles maximum.
- Round-robin rule:
  - Search starts at the pointer index and wraps upward modulo NUM_REQ.
  - The first asserted req wins.
  - The pointer only changes in ACK.
- Request handling:
  - req changes during XFER/ACK do not affect the transfer in flight.
  - A dropped req still completes with done.
- Handshake: the requester deasserts req on the edge ending its done cycle. The IDLE cycle that follows therefore never re-grants a completed request.
- Index cases:
  - src == dst is legal; performs a normal transfer.
  - Any index 0..2**REG_SEL_W-1 is legal.
- Output timing: all outputs are registered (driven from state and latched fields); no combinational path from req to outputs.
- Invariant: at most one grant bit and at most one rin bit are high in any cycle; rin is non-zero only in XFER.

Optional Feature:
- Macro: BUS_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority; the lowest-indexed asserted req always wins. The pointer register is not implemented and the ACK pointer update is removed.
- Undefined (default): round-robin as above.
- Timing and handshakes are identical either way.

Test Plan:
- Reset/idle:
  - Stimulus: assert clear with all req=0, release it, run 5 cycles.
  - Required: all outputs 0, busy=0 throughout.
- Single transfer:
  - Stimulus: req=4'b0010 with requester 1 src=3, dst=7.
  - Required, cycle+1: grant=0010, bus_sel=3, bus_oe=1, rin=16'h0080.
  - Required, cycle+2: done=0010, rin=0.
  - Required, cycle+3: busy=0.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held; each requester drops req after its done.
  - Required: grant order 0,1,2,3. With requester 0 re-requesting after its done, the next winner is 0 only after 1, 2 and 3 have each been served.
- Wrap-around:
  - Stimulus: pointer at 3 after serving requester 2; req=4'b1001.
  - Required: requester 3 wins first, then 0.
- Mid-transfer reset:
  - Stimulus: assert clear during XFER with rin=16'h0080.
  - Required: rin=0 and bus_oe=0 before the next clock edge, no done, pointer=0, state IDLE.
- Fixed priority (BUS_ARB_FIXED_PRIORITY_EN defined):
  - Stimulus: req=4'b1100 held continuously.
  - Required: requester 2 is granted on every transfer; requester 3 is never granted while req[2] stays high.

Source files
------------

// File: rtl/bus_transfer_arbiter.sv
// -----------------------------------------------------------------------------
// bus_transfer_arbiter
//
// Shares one internal bus among NUM_REQ requesters. Each requester asks for a
// single register-to-register move (src -> dst). A granted move runs a fixed
// IDLE -> XFER -> ACK sequence: during XFER the bus-mux select, source output
// enable and one-hot destination enable are driven, so the destination register
// captures the bus on the edge that ends XFER. ACK returns a one-cycle done
// pulse to the winner.
//
// Arbitration is round-robin by default. Defining BUS_ARB_FIXED_PRIORITY_EN
// switches to fixed priority (lowest asserted index wins) and removes the
// round-robin pointer. Timing and handshakes are the same in both builds.
//
// Ports:
//   clock    in   rising-edge system clock
//   clear    in   asynchronous active-high reset (aborts any move in flight)
//   req      in   per-requester request, held until that requester's done
//   src_sel  in   flattened source indices, requester i at [i*REG_SEL_W +: REG_SEL_W]
//   dst_sel  in   flattened destination indices, same packing
//   grant    out  one-hot winner, high during XFER and ACK
//   bus_sel  out  bus-mux select (latched source index)
//   bus_oe   out  source drive enable, XFER only
//   rin      out  one-hot destination register enable, XFER only
//   done     out  one-cycle completion pulse to the winner, ACK only
//   busy     out  high whenever the sequencer is not idle
//
// All outputs come straight from flops; req has no combinational path to them.
// -----------------------------------------------------------------------------
module bus_transfer_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int REG_SEL_W = 4
) (
  input  logic                           clock,
  input  logic                           clear,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*REG_SEL_W-1:0]   src_sel,
  input  logic [NUM_REQ*REG_SEL_W-1:0]   dst_sel,
  output logic [NUM_REQ-1:0]             grant,
  output logic [REG_SEL_W-1:0]           bus_sel,
  output logic                           bus_oe,
  output logic [(2**REG_SEL_W)-1:0]      rin,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy
);

  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam int RF_SIZE = 2**REG_SEL_W;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_XFER = 2'b01;
  localparam logic [1:0] ST_ACK  = 2'b10;

  logic [1:0]             state_q,   state_d;
  logic [PTR_W-1:0]       winner_q,  winner_d;
  logic [REG_SEL_W-1:0]   src_q,     src_d;
  logic [REG_SEL_W-1:0]   dst_q,     dst_d;

  logic [NUM_REQ-1:0]     grant_q,   grant_d;
  logic [REG_SEL_W-1:0]   bus_sel_q, bus_sel_d;
  logic                   bus_oe_q,  bus_oe_d;
  logic [RF_SIZE-1:0]     rin_q,     rin_d;
  logic [NUM_REQ-1:0]     done_q,    done_d;
  logic                   busy_q,    busy_d;

  logic [REG_SEL_W-1:0]   src_arr_s [NUM_REQ];
  logic [REG_SEL_W-1:0]   dst_arr_s [NUM_REQ];
  logic [PTR_W-1:0]       start_s;
  logic [PTR_W-1:0]       win_idx_s;
  logic                   win_found_s;

  // Unpack the flattened index buses so the winner can select its slice.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign src_arr_s[gi] = src_sel[gi*REG_SEL_W +: REG_SEL_W];
    assign dst_arr_s[gi] = dst_sel[gi*REG_SEL_W +: REG_SEL_W];
  end

`ifdef BUS_ARB_FIXED_PRIORITY_EN
  // Fixed priority: the search always begins at requester 0.
  assign start_s = '0;
`else
  logic [PTR_W-1:0] ptr_q, ptr_d;

  assign start_s = ptr_q;

  // Pointer advances past the winner only when its move is acknowledged.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_ACK) begin
      ptr_d = (winner_q == PTR_W'(NUM_REQ - 1)) ? '0 : (winner_q + PTR_W'(1));
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Scan requesters from start_s upward with wrap; the first asserted one wins.
  always_comb begin
    int cand;
    cand        = 0;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(start_s) + k;
      cand = (cand >= NUM_REQ) ? (cand - NUM_REQ) : cand;
      win_idx_s   = (!win_found_s && req[cand[PTR_W-1:0]]) ? cand[PTR_W-1:0] : win_idx_s;
      win_found_s = win_found_s | req[cand[PTR_W-1:0]];
    end
  end

  // Sequencer next state plus next values of every registered output.
  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    src_d     = src_q;
    dst_d     = dst_q;
    grant_d   = '0;
    bus_sel_d = '0;
    bus_oe_d  = 1'b0;
    rin_d     = '0;
    done_d    = '0;
    busy_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d            = ST_XFER;
          winner_d           = win_idx_s;
          src_d              = src_arr_s[win_idx_s];
          dst_d              = dst_arr_s[win_idx_s];
          grant_d[win_idx_s] = 1'b1;
          bus_sel_d          = src_arr_s[win_idx_s];
          bus_oe_d           = 1'b1;
          rin_d[dst_arr_s[win_idx_s]] = 1'b1;
          busy_d             = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        // The destination has captured the bus; acknowledge the winner.
        state_d           = ST_ACK;
        grant_d[winner_q] = 1'b1;
        done_d[winner_q]  = 1'b1;
        bus_sel_d         = src_q;
        busy_d            = 1'b1;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched transfer fields and output registers; clear aborts at once.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      winner_q  <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      grant_q   <= '0;
      bus_sel_q <= '0;
      bus_oe_q  <= 1'b0;
      rin_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      grant_q   <= grant_d;
      bus_sel_q <= bus_sel_d;
      bus_oe_q  <= bus_oe_d;
      rin_q     <= rin_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign grant   = grant_q;
  assign bus_sel = bus_sel_q;
  assign bus_oe  = bus_oe_q;
  assign rin     = rin_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
module tb_bus_transfer_arbiter;

  logic        clock;
  logic        clear;
  logic [3:0]  req;
  logic [15:0] src_sel;
  logic [15:0] dst_sel;
  logic [3:0]  grant;
  logic [3:0]  bus_sel;
  logic        bus_oe;
  logic [15:0] rin;
  logic [3:0]  done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;   // reference round-robin pointer

  bus_transfer_arbiter #(.NUM_REQ(4), .REG_SEL_W(4)) dut (
    .clock   (clock),
    .clear   (clear),
    .req     (req),
    .src_sel (src_sel),
    .dst_sel (dst_sel),
    .grant   (grant),
    .bus_sel (bus_sel),
    .bus_oe  (bus_oe),
    .rin     (rin),
    .done    (done),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"},   32'(grant),   32'h0);
    chk({tag, "_bus_sel"}, 32'(bus_sel), 32'h0);
    chk({tag, "_bus_oe"},  32'(bus_oe),  32'h0);
    chk({tag, "_rin"},     32'(rin),     32'h0);
    chk({tag, "_done"},    32'(done),    32'h0);
    chk({tag, "_busy"},    32'(busy),    32'h0);
  endtask

  // First asserted request at or after the search start, wrapping.
  function automatic int model_winner(input logic [3:0] r);
    int start;
`ifdef BUS_ARB_FIXED_PRIORITY_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  // One arbitration round starting in IDLE; ends one cycle into the next IDLE.
  task automatic run_xfer(input logic [3:0] r, input logic [15:0] s, input logic [15:0] d,
                          output logic [3:0] g_obs);
    int w;
    int es;
    int ed;
    req     = r;
    src_sel = s;
    dst_sel = d;
    w = model_winner(r);
    if (w < 0) begin
      tick;
      g_obs = grant;
      chk_idle("noreq");
      return;
    end
    es = int'(s[w*4 +: 4]);
    ed = int'(d[w*4 +: 4]);
    tick;
    g_obs = grant;
    chk("xfer_grant",   32'(grant),   32'(1) << w);
    chk("xfer_bus_sel", 32'(bus_sel), 32'(es));
    chk("xfer_bus_oe",  32'(bus_oe),  32'h1);
    chk("xfer_rin",     32'(rin),     32'(1) << ed);
    chk("xfer_done",    32'(done),    32'h0);
    chk("xfer_busy",    32'(busy),    32'h1);
    // Changes while the move is in flight must not disturb it.
    req     = 4'($urandom);
    src_sel = 16'($urandom);
    dst_sel = 16'($urandom);
    tick;
    chk("ack_grant",  32'(grant),  32'(1) << w);
    chk("ack_done",   32'(done),   32'(1) << w);
    chk("ack_rin",    32'(rin),    32'h0);
    chk("ack_bus_oe", 32'(bus_oe), 32'h0);
    chk("ack_busy",   32'(busy),   32'h1);
    m_ptr = (w + 1) % 4;
    tick;
    chk_idle("post");
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] pend;
    clear   = 1'b1;
    req     = 4'b0000;
    src_sel = 16'h0000;
    dst_sel = 16'h0000;

    // Reset and idle behaviour.
    #1;
    chk_idle("in_reset");
    tick;
    tick;
    clear = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk_idle("idle");
    end

    // Single transfer with explicit expectations: requester 1, src 3, dst 7.
    req     = 4'b0010;
    src_sel = 16'h0030;
    dst_sel = 16'h0070;
    tick;
    chk("st_grant",   32'(grant),   32'h2);
    chk("st_bus_sel", 32'(bus_sel), 32'h3);
    chk("st_bus_oe",  32'(bus_oe),  32'h1);
    chk("st_rin",     32'(rin),     32'h0080);
    chk("st_done0",   32'(done),    32'h0);
    tick;
    chk("st_done",    32'(done),    32'h2);
    chk("st_rin_ack", 32'(rin),     32'h0);
    req = 4'b0000;
    tick;
    chk("st_busy",    32'(busy),    32'h0);
`ifndef BUS_ARB_FIXED_PRIORITY_EN
    m_ptr = 2;
`endif

    // Mid-transfer clear: requester 1 again, abort while in XFER.
    req     = 4'b0010;
    src_sel = 16'h0030;
    dst_sel = 16'h0070;
    tick;
    chk("mr_rin_pre", 32'(rin), 32'h0080);
    #2;
    clear = 1'b1;
    #1;
    chk_idle("mr_async");
    tick;
    chk_idle("mr_held");
    clear = 1'b0;
    m_ptr = 0;
    // Pointer back at 0: with requesters 1 and 2 pending, 1 must win.
    run_xfer(4'b0110, 16'h0000, 16'h0000, g);
`ifndef BUS_ARB_FIXED_PRIORITY_EN
    chk("mr_ptr_zero", 32'(g), 32'h2);
`else
    chk("mr_fixed", 32'(g), 32'h2);
`endif

    // Boundary indices: src == dst at both ends of the register file.
    run_xfer(4'b1000, 16'hF000, 16'hF000, g);
    chk("edge_hi", 32'(g), 32'h8);
    run_xfer(4'b0001, 16'h0000, 16'h0000, g);
    chk("edge_lo", 32'(g), 32'h1);

`ifndef BUS_ARB_FIXED_PRIORITY_EN
    // Fairness: all request, each drops after done; 0 re-requests at once.
    // Pointer is 1 here, so first re-align by serving requester 3.
    run_xfer(4'b1000, 16'h1234, 16'h4321, g);
    pend = 4'b1111;
    run_xfer(pend, 16'h3210, 16'h0123, g);
    chk("rr_first0", 32'(g), 32'h1);
    pend = 4'b1111;   // requester 0 comes straight back
    run_xfer(pend, 16'h3210, 16'h0123, g);
    chk("rr_1", 32'(g), 32'h2);
    pend = pend & ~g;
    run_xfer(pend, 16'h3210, 16'h0123, g);
    chk("rr_2", 32'(g), 32'h4);
    pend = pend & ~g;
    run_xfer(pend, 16'h3210, 16'h0123, g);
    chk("rr_3", 32'(g), 32'h8);
    pend = pend & ~g;
    run_xfer(pend, 16'h3210, 16'h0123, g);
    chk("rr_0_again", 32'(g), 32'h1);

    // Wrap-around: serve 2 so the pointer sits at 3, then 3 beats 0.
    run_xfer(4'b0100, 16'h0500, 16'h0A00, g);
    run_xfer(4'b1001, 16'hC00D, 16'h2005, g);
    chk("wrap_3", 32'(g), 32'h8);
    run_xfer(4'b0001, 16'hC00D, 16'h2005, g);
    chk("wrap_0", 32'(g), 32'h1);
`else
    // Fixed priority: requester 2 wins every round while 2 and 3 request.
    for (int i = 0; i < 4; i++) begin
      run_xfer(4'b1100, 16'h9876, 16'h6789, g);
      chk("fixed_2", 32'(g), 32'h4);
    end
`endif

    // Randomized rounds against the reference model.
    for (int i = 0; i < 40; i++) begin
      run_xfer(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
